// File: rtl/ws2812_frame_ctl.sv
// WS2812 frame sequencer: fetches pixel words from a 1-cycle RAM, serialises them GRB MSB-first
// over a bit_rdy/bit_done handshake, then holds a latch gap. Define WS2812_RGBW_EN for 32-bit RGBW.
module ws2812_frame_ctl #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [15:0] CNT_LATCH = 16'd12000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] led_num_in,
    output logic              ram_rd_en_out,
    output logic [ADDR_W-1:0] ram_rd_addr_out,
`ifdef WS2812_RGBW_EN
    input  logic [31:0]       ram_rd_data_in,
`else
    input  logic [23:0]       ram_rd_data_in,
`endif
    output logic              bit_rdy_out,
    output logic              bit_data_out,
    input  logic              bit_done_in,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [2:0]        fsm_state_out
);

`ifdef WS2812_RGBW_EN
    localparam int PIX_W = 32;
`else
    localparam int PIX_W = 24;
`endif
    localparam logic [4:0]        BIT_LAST = 5'(PIX_W - 1);
    localparam logic [ADDR_W-1:0] PIX_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_LATCH = 3'd5
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] num_q;
    logic [ADDR_W-1:0] pix_idx_q;
    logic [4:0]        bit_idx_q;
    logic [PIX_W-1:0]  shift_q;
    logic [15:0]       latch_cnt_q;
    logic              rd_en_q;
    logic              rdy_q;
    logic              data_q;
    logic              busy_q;
    logic              done_q;
    logic [PIX_W-1:0]  pix_wire;

    // RAM holds {R,G,B[,W]}; the wire wants G first, then R, then B[,W].
`ifdef WS2812_RGBW_EN
    assign pix_wire = {ram_rd_data_in[23:16], ram_rd_data_in[31:24], ram_rd_data_in[15:0]};
`else
    assign pix_wire = {ram_rd_data_in[15:8], ram_rd_data_in[23:16], ram_rd_data_in[7:0]};
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            pix_idx_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            latch_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            rdy_q       <= 1'b0;
            data_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped so frames never overlap.
                    if (start_in && !done_q) begin
                        num_q     <= led_num_in;
                        pix_idx_q <= '0;
                        busy_q    <= 1'b1;
                        if (led_num_in == '0) begin
                            latch_cnt_q <= '0;
                            state_q     <= S_LATCH;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: state_q <= S_LOAD;
                S_LOAD: begin
                    shift_q   <= pix_wire;
                    bit_idx_q <= '0;
                    data_q    <= pix_wire[PIX_W-1];
                    rdy_q     <= 1'b1;
                    state_q   <= S_SEND;
                end
                S_SEND: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bit_done_in) begin
                        if (bit_idx_q != BIT_LAST) begin
                            shift_q   <= shift_q << 1;
                            bit_idx_q <= bit_idx_q + 5'd1;
                            data_q    <= shift_q[PIX_W-2];
                            rdy_q     <= 1'b1;
                            state_q   <= S_SEND;
                        end else if (pix_idx_q == num_q - PIX_ONE) begin
                            latch_cnt_q <= '0;
                            state_q     <= S_LATCH;
                        end else begin
                            pix_idx_q <= pix_idx_q + PIX_ONE;
                            rd_en_q   <= 1'b1;
                            state_q   <= S_READ;
                        end
                    end
                end
                S_LATCH: begin
                    if (latch_cnt_q == CNT_LATCH - 16'd1) begin
                        latch_cnt_q <= '0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_rd_en_out   = rd_en_q;
    assign ram_rd_addr_out = pix_idx_q;
    assign bit_rdy_out     = rdy_q;
    assign bit_data_out    = data_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = done_q;
    assign fsm_state_out   = state_q;

endmodule

// File: tb/tb_ws2812_frame_ctl.sv
// Bench for ws2812_frame_ctl: random encoder delays and frames, checked every cycle against an
// event-timing model built from the frame rules, plus literal expectations for the directed cases.
module tb_ws2812_frame_ctl;

`ifdef WS2812_RGBW_EN
    localparam int PIX_W = 32;
`else
    localparam int PIX_W = 24;
`endif
    localparam int          ADDR_W    = 8;
    localparam logic [15:0] CNT_LATCH = 16'd40;
    localparam int          LATCH_I   = 40;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              start_in = 1'b0;
    logic [ADDR_W-1:0] led_num_in = '0;
    logic              ram_rd_en_out;
    logic [ADDR_W-1:0] ram_rd_addr_out;
    logic [PIX_W-1:0]  ram_rd_data = '0;
    logic              bit_rdy_out;
    logic              bit_data_out;
    logic              bit_done_in;
    logic              busy_out;
    logic              frame_done_out;
    logic [2:0]        fsm_state_out;

    logic enc_done = 1'b0;
    logic spur     = 1'b0;
    bit   spur_en  = 1'b0;
    assign bit_done_in = enc_done | spur;

    ws2812_frame_ctl #(.ADDR_W(ADDR_W), .CNT_LATCH(CNT_LATCH)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .led_num_in     (led_num_in),
        .ram_rd_en_out  (ram_rd_en_out),
        .ram_rd_addr_out(ram_rd_addr_out),
        .ram_rd_data_in (ram_rd_data),
        .bit_rdy_out    (bit_rdy_out),
        .bit_data_out   (bit_data_out),
        .bit_done_in    (bit_done_in),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .fsm_state_out  (fsm_state_out)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- pixel RAM model (1-cycle read latency) ----------------
    logic [PIX_W-1:0] ram [256];
    initial forever begin
        @(posedge clk_in);
        if (ram_rd_en_out) ram_rd_data <= ram[ram_rd_addr_out];
        else               ram_rd_data <= PIX_W'($urandom);
    end

    // ---------------- encoder model: bit_done 3..300 cycles after bit_rdy ----------------
    initial begin : encoder
        int d;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && bit_rdy_out) begin
                d = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 300) : $urandom_range(3, 12);
                repeat (d) @(posedge clk_in);
                #1 enc_done = 1'b1;
                @(posedge clk_in);
                #1 enc_done = 1'b0;
            end
        end
    end

    // ---------------- behavioural model state ----------------
    bit   m_active = 1'b0;
    bit   m_in_wait = 1'b0;
    int   m_rd_due = -1, m_rdy_due = -1, m_done_due = -1, m_rdy_at = -1;
    int   m_pix = 0, m_n = 0, m_bits_left = 0;
    logic m_data = 1'b0;
    logic exp_bits[$];

    // Wire order is G,R,B[,W], every byte MSB first; RAM word is {R,G,B[,W]}.
    task automatic push_pixel(input logic [PIX_W-1:0] w);
        logic [7:0] bytes[4];
        int nb;
        bytes[0] = w[PIX_W-9 -: 8];
        bytes[1] = w[PIX_W-1 -: 8];
        bytes[2] = w[PIX_W-17 -: 8];
        bytes[3] = w[7:0];
        nb = PIX_W / 8;
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) exp_bits.push_back(bytes[b][i]);
    endtask

    // ---------------- single compare process ----------------
    initial begin : compare_proc
        int c;
        bit e_rd, e_rdy, e_done, e_busy;
        forever begin
            @(negedge clk_in);
            c = cyc;
            if (!rst_n_in) begin
                check("rst_rd_en",   64'(ram_rd_en_out),   64'(0));
                check("rst_rd_addr", 64'(ram_rd_addr_out), 64'(0));
                check("rst_bit_rdy", 64'(bit_rdy_out),     64'(0));
                check("rst_bit_data",64'(bit_data_out),    64'(0));
                check("rst_busy",    64'(busy_out),        64'(0));
                check("rst_done",    64'(frame_done_out),  64'(0));
                m_active = 0; m_in_wait = 0;
                m_rd_due = -1; m_rdy_due = -1; m_done_due = -1;
                exp_bits.delete();
            end else begin
                e_rd   = (c == m_rd_due);
                e_rdy  = (c == m_rdy_due);
                e_done = (c == m_done_due);
                e_busy = m_active && !e_done;
                check("rd_en",      64'(ram_rd_en_out),  64'(e_rd));
                check("bit_rdy",    64'(bit_rdy_out),    64'(e_rdy));
                check("frame_done", 64'(frame_done_out), 64'(e_done));
                check("busy",       64'(busy_out),       64'(e_busy));
                if (e_rd) check("rd_addr", 64'(ram_rd_addr_out), 64'(m_pix));
                if (e_rdy) begin
                    if (exp_bits.size() == 0) begin
                        check("bits_pending", 64'(exp_bits.size()), 64'(1));
                    end else begin
                        m_data    = exp_bits.pop_front();
                        m_in_wait = 1;
                        m_rdy_at  = c;
                    end
                end
                if (m_in_wait) check("bit_data", 64'(bit_data_out), 64'(m_data));

                if (e_rd) begin
                    m_rdy_due   = c + 2;
                    m_bits_left = PIX_W;
                end
                if (e_done) begin
                    m_active   = 0;
                    m_done_due = -1;
                end
                if (m_in_wait && c > m_rdy_at && bit_done_in) begin
                    m_in_wait = 0;
                    m_bits_left--;
                    if (m_bits_left > 0)      m_rdy_due  = c + 1;
                    else if (m_pix == m_n - 1) m_done_due = c + 1 + LATCH_I;
                    else begin
                        m_pix++;
                        m_rd_due = c + 1;
                    end
                end
                if (start_in && !m_active && !e_done) begin
                    m_active = 1;
                    m_n      = int'(led_num_in);
                    m_pix    = 0;
                    exp_bits.delete();
                    for (int p = 0; p < m_n; p++) push_pixel(ram[p]);
                    if (m_n == 0) m_done_due = c + 1 + LATCH_I;
                    else          m_rd_due   = c + 1;
                end
            end
        end
    end

    // ---------------- event monitor for literal expectations ----------------
    int          n_rdy = 0, n_rd = 0, n_done = 0, done_cyc = 0, bd_cyc = 0;
    logic [63:0] log_bits = '0;
    initial forever begin
        @(negedge clk_in);
        if (bit_rdy_out) begin
            n_rdy++;
            log_bits = {log_bits[62:0], bit_data_out};
        end
        if (ram_rd_en_out)  n_rd++;
        if (frame_done_out) begin n_done++; done_cyc = cyc; end
        if (enc_done)       bd_cyc = cyc;
    end

    // ---------------- spurious bit_done injector (LOAD and LATCH only) ----------------
    initial forever begin
        @(negedge clk_in);
        #1;
        if (spur_en && rst_n_in && ram_rd_en_out) begin
            @(posedge clk_in); #1 spur = 1'b1;
            @(posedge clk_in); #1 spur = 1'b0;
        end else if (spur_en && rst_n_in && m_done_due > 0 && cyc >= m_done_due - LATCH_I &&
                     cyc + 2 <= m_done_due - 1 && $urandom_range(0, 3) == 0) begin
            @(posedge clk_in); #1 spur = 1'b1;
            @(posedge clk_in); #1 spur = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    int st_cyc = 0;

    task automatic pulse_start(input logic [ADDR_W-1:0] n);
        @(posedge clk_in); #1;
        led_num_in = n;
        start_in   = 1'b1;
        st_cyc     = cyc;
        @(posedge clk_in); #1;
        start_in   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int idle = 0;
        int k = 0;
        while (idle < 3 && k < budget) begin
            @(negedge clk_in); #1;
            k++;
            if (busy_out || frame_done_out) idle = 0;
            else                            idle++;
        end
        check("idle_within_budget", 64'(idle >= 3), 64'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (95000) @(posedge clk_in);
        $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        int b_rdy, b_rd, b_done, k;
        for (int i = 0; i < 256; i++) ram[i] = PIX_W'($urandom);
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

`ifdef WS2812_RGBW_EN
        // W byte goes out after B: only sent bit 24 is set.
        ram[0] = 32'h00000080;
        b_rdy = n_rdy; b_done = n_done;
        pulse_start(8'd1);
        wait_idle(20000);
        check("t6_bit_count", 64'(n_rdy - b_rdy), 64'(32));
        check("t6_bits",      {32'h0, log_bits[31:0]}, 64'h0000_0000_0000_0080);
        check("t6_done_count",64'(n_done - b_done), 64'(1));
`else
        // Two-pixel frame with hand-derived GRB bit stream.
        ram[0] = 24'hFF0000;
        ram[1] = 24'h00FF01;
        b_rdy = n_rdy; b_done = n_done;
        pulse_start(8'd2);
        wait_idle(30000);
        check("t1_bit_count", 64'(n_rdy - b_rdy), 64'(48));
        check("t1_bits",      {16'h0, log_bits[47:0]}, 64'h0000_00FF_00FF_0001);
        check("t1_done_count",64'(n_done - b_done), 64'(1));
        check("t1_latch_gap", 64'(done_cyc - bd_cyc), 64'(LATCH_I + 1));
`endif

        // Empty frame: latch gap only.
        b_rdy = n_rdy; b_rd = n_rd; b_done = n_done;
        pulse_start(8'd0);
        wait_idle(2000);
        check("t2_rd_count",   64'(n_rd - b_rd),     64'(0));
        check("t2_rdy_count",  64'(n_rdy - b_rdy),   64'(0));
        check("t2_done_count", 64'(n_done - b_done), 64'(1));
        check("t2_done_delay", 64'(done_cyc - st_cyc), 64'(LATCH_I + 1));

        // Start held across a whole frame and its done cycle.
        b_done = n_done;
        @(posedge clk_in); #1;
        led_num_in = 8'd1;
        start_in   = 1'b1;
        k = 0;
        do begin
            @(negedge clk_in); #1;
            k++;
        end while (!frame_done_out && k < 20000);
        check("t3_done_seen",  64'(frame_done_out), 64'(1));
        check("t3_done_count", 64'(n_done - b_done), 64'(1));
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        check("t3_restart_busy", 64'(busy_out), 64'(1));
        repeat (20) @(posedge clk_in);
        pulse_start(8'd3);
        wait_idle(20000);
        repeat (60) @(posedge clk_in);
        check("t3_total_done", 64'(n_done - b_done), 64'(2));
        check("t3_idle_busy",  64'(busy_out), 64'(0));

        // Reset during WAIT of pixel 1, bit 10.
        b_rdy = n_rdy;
        pulse_start(8'd2);
        k = 0;
        while (n_rdy - b_rdy < PIX_W + 11 && k < 30000) begin
            @(negedge clk_in); #1;
            k++;
        end
        check("t4_reached_bit", 64'(n_rdy - b_rdy), 64'(PIX_W + 11));
        b_done = n_done;
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        #1;
        check("t4_rd_en",  64'(ram_rd_en_out),   64'(0));
        check("t4_addr",   64'(ram_rd_addr_out), 64'(0));
        check("t4_rdy",    64'(bit_rdy_out),     64'(0));
        check("t4_data",   64'(bit_data_out),    64'(0));
        check("t4_busy",   64'(busy_out),        64'(0));
        check("t4_done",   64'(frame_done_out),  64'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (320) @(posedge clk_in);
        check("t4_no_done", 64'(n_done - b_done), 64'(0));
        ram[0] = PIX_W'($urandom);
        pulse_start(8'd1);
        wait_idle(20000);

        // Spurious bit_done during LOAD and LATCH.
        spur_en = 1'b1;
        for (int i = 0; i < 3; i++) ram[i] = PIX_W'($urandom);
        pulse_start(8'd3);
        wait_idle(30000);
        spur_en = 1'b0;

        // Randomised frames, with occasional extra starts.
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 5; i++) ram[i] = PIX_W'($urandom);
            spur_en = ($urandom_range(0, 1) == 1);
            pulse_start(8'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 60)) @(posedge clk_in);
                pulse_start(8'($urandom_range(1, 4)));
            end
            wait_idle(30000);
            spur_en = 1'b0;
        end

        repeat (5) @(posedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
